// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit SRAM half-word accesses and holds ready low while the access runs.
// Ports: clk, rst (async, active-high); wr_en/rd_en/addr/wdata in from EX/MEM;
// rdata/ready out to MEM/WB; sram_addr/sram_dq_out/sram_we_n/sram_oe_n out and
// sram_dq_in in for the external SRAM.
module mem_stage_sram_ctrl #(
  parameter int WORD_WIDTH  = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [SRAM_DW-1:0]    sram_dq_out,
  input  logic [SRAM_DW-1:0]    sram_dq_in,
  output logic                  sram_we_n,
  output logic                  sram_oe_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int CW  = $clog2(WAIT_CYCLES + 1);
  localparam int WAW = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  op_wr;
  logic [WAW-1:0]        waddr_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [SRAM_DW-1:0]    lo_q;
  logic [WORD_WIDTH-1:0] off;
  logic [WAW-1:0]        waddr;

  // Word index relative to the SRAM window; wraps, no range check.
  assign off   = addr - WORD_WIDTH'(ADDR_BASE);
  assign waddr = WAW'(off >> 2);

  // Enables seen in DONE still belong to the finishing request.
  assign ready = (state == DONE) ||
                 (state == IDLE && !wr_en && !rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_en || rd_en) begin
            op_wr       <= wr_en;
            waddr_q     <= waddr;
            wdata_q     <= wdata;
            cnt         <= '0;
            sram_addr   <= {waddr, 1'b0};
            sram_dq_out <= wdata[SRAM_DW-1:0];
            sram_we_n   <= ~wr_en;
            sram_oe_n   <= wr_en;
            state       <= LO;
          end
        end
        LO: begin
          if (cnt == CNT_LAST) begin
            lo_q        <= sram_dq_in;
            cnt         <= '0;
            sram_addr   <= {waddr_q, 1'b1};
            sram_dq_out <= wdata_q[WORD_WIDTH-1:SRAM_DW];
            state       <= HI;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HI: begin
          if (cnt == CNT_LAST) begin
            if (!op_wr) rdata <= {sram_dq_in, lo_q};
            cnt       <= '0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: behavioural 16-bit SRAM, vector table of
// loads/stores with a rdata scoreboard, plus back-to-back and reset cases.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_we_n, sram_oe_n;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!sram_we_n) mem[sram_addr[5:0]] = sram_dq_out;
  end

  assign sram_dq_in = sram_oe_n ? 16'h0 : mem[sram_addr[5:0]];

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one request and holds it until ready; returns latency
  // and the cycle number the request was first seen.
  task automatic do_req(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd,
                        output int lat, output int start);
    @(posedge clk); #1;
    wr_en = w; rd_en = r; addr = a; wdata = d;
    start = cyc;
    sb.push_back(exp_rd);
    lat = 0;
    #1;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) begin
      fails++; checks++;
      $display("FAIL timeout: ready stuck 0 at addr %h", a);
    end
    chk("rdata", rdata, sb.pop_front());
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, st, st0, h;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    vecs[0] = '{1, 0, 32'd1024, 32'hDEADBEEF, 32'h0,        5};
    vecs[1] = '{0, 1, 32'd1024, 32'h0,        32'hDEADBEEF, 5};
    vecs[2] = '{1, 1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5};
    vecs[3] = '{0, 1, 32'd1028, 32'h0,        32'h12345678, 5};
    vecs[4] = '{1, 0, 32'd1064, 32'hA5A55A5A, 32'h12345678, 5};
    vecs[5] = '{0, 1, 32'd1064, 32'h0,        32'hA5A55A5A, 5};

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst rdata", rdata, 32'h0);
    chk("rst ready", {31'h0, ready}, 32'h1);
    chk("rst we_n", {31'h0, sram_we_n}, 32'h1);
    chk("rst oe_n", {31'h0, sram_oe_n}, 32'h1);
    chk("rst sram_addr", {14'h0, sram_addr}, 32'h0);
    rst = 1'b0;
    go_idle(1);

    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, lat, st);
      chk("latency", lat, vecs[i].exp_lat);
      if (vecs[i].wr) begin
        h = ((vecs[i].addr - 1024) >> 2) * 2;
        chk("half lo", {16'h0, mem[h]},
            {16'h0, vecs[i].wdata[15:0]});
        chk("half hi", {16'h0, mem[h+1]},
            {16'h0, vecs[i].wdata[31:16]});
      end
      go_idle(1);
    end

    do_req(0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, lat, st0);
    do_req(0, 1, 32'd1028, 32'h0, 32'h12345678, lat, st);
    chk("b2b start", st - st0, 6);
    chk("b2b ready", cyc - st0, 11);
    go_idle(2);

    @(posedge clk); #1;
    wr_en = 1'b1; rd_en = 1'b0;
    addr = 32'd1040; wdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("hi we_n", {31'h0, sram_we_n}, 32'h0);
    rst = 1'b1;
    #1;
    chk("abort we_n", {31'h0, sram_we_n}, 32'h1);
    chk("abort oe_n", {31'h0, sram_oe_n}, 32'h1);
    wr_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort ready", {31'h0, ready}, 32'h1);
    chk("abort lo", {16'h0, mem[8]}, 32'h0000F00D);
    chk("abort hi", {16'h0, mem[9]}, 32'h0);
    chk("abort rdata", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
